shot_hit_scanner: RTL and testbench
===================================

// Module: shot_hit_scanner
// PURPOSE
//  Reader side of the shot table. Once per frame it walks every shot slot through a
//  1-cycle-latency read port and tests each valid shot against the live duck's box.
//  On the first overlap it pulses kill/kill_addr, so the table owner clears that slot's
//  valid bit, and it raises hit for one cycle. A saturating score counter is kept.
//  Sits between the shot table and the duck/score logic.
// PARAMETERS
//  N_SLOTS  64  shot slots scanned, 0..N_SLOTS-1
//  ADDR_W   6   slot address width, = clog2(N_SLOTS)
//  DUCK_W   32  duck box width, pixels
//  DUCK_H   32  duck box height, pixels
//  SHOT_W   4   shot box width, pixels
//  SHOT_H   8   shot box height, pixels
//  SCORE_W  16  score counter width
// PORTS
//  clk          in   1        clock
//  reset        in   1        reset, synchronous, active-high
//  frame_start  in   1        1-cycle pulse: begin a scan
//  duck_x       in   10       duck left edge, unsigned
//  duck_y       in   10       duck top edge, signed
//  duck_alive   in   1        duck present; scanning only while 1
//  rd_addr      out  ADDR_W   slot read address to the shot table
//  rd_valid     in   1        slot valid bit, data for rd_addr of the previous cycle
//  rd_x         in   10       slot x, unsigned, same timing as rd_valid
//  rd_y         in   10       slot y, signed, same timing as rd_valid
//  kill         out  1        1-cycle pulse: clear slot kill_addr
//  kill_addr    out  ADDR_W   slot to clear; held until the next kill
//  hit          out  1        1-cycle pulse, coincident with kill
//  score        out  SCORE_W  hits so far, saturating
//  busy         out  1        high while a scan is in progress
// BEHAVIOUR
//  - Reset: state IDLE. rd_addr, kill, kill_addr, hit, score and busy are all 0.
//    Reset wins over every other event and aborts a scan in progress without a kill.
//  - FSM: IDLE -> ISSUE -> CHECK -> (ISSUE | KILL | IDLE); KILL -> IDLE.
//  - IDLE: when frame_start=1 and duck_alive=1, load rd_addr=0 and go to ISSUE; busy=1
//    from the next cycle. frame_start is ignored in every state other than IDLE.
//  - ISSUE: rd_addr is stable and the table answers next cycle. Go to CHECK.
//  - CHECK: sample rd_valid, rd_x, rd_y and evaluate overlap. Each slot takes 2 cycles;
//    a full scan with no hit takes 2*N_SLOTS cycles.
//  - Overlap: rd_valid & (rd_x+SHOT_W > duck_x) & (rd_x < duck_x+DUCK_W) &
//    (rd_y+SHOT_H > duck_y) & (rd_y < duck_y+DUCK_H).
//    All terms use 12-bit signed arithmetic; x is zero-extended, y is sign-extended.
//    Edges that only touch are not a hit (strict compares).
//  - CHECK with overlap: register kill_addr=rd_addr and go to KILL.
//  - CHECK with no overlap: if rd_addr==N_SLOTS-1 go to IDLE (no wrap to 0, busy
//    drops); otherwise rd_addr+1 and go to ISSUE.
//  - KILL: kill=1 and hit=1 for exactly one cycle. score+1, held at all-ones once
//    saturated. Then go to IDLE. At most one hit per scan.
//  - duck_alive falling in ISSUE or CHECK: go to IDLE on the next edge with no hit.
//    A CHECK-cycle overlap is discarded if duck_alive=0 in that same cycle.
//  - duck_x and duck_y are sampled live each CHECK cycle; the owner keeps them stable
//    during a scan.
//  - The table owner clears the killed slot within 1 cycle; the scanner does not retry.
// STRUCTURE
//  - Shared package: FSM state encoding (IDLE, ISSUE, CHECK, KILL), the shot and duck
//    box size constants, and the 10-bit coordinate width.
//  - One natural sub-module: box_overlap. It is purely combinational, takes two
//    boxes, outputs overlap, and is reused by the duck/duck and shot/shot checks.
//  - The FSM, address counter and score counter stay in this module.
// TESTING
//  1 Reset mid-scan at rd_addr=10 -> next cycle busy=0, rd_addr=0, no kill, score unchanged.
//  2 Duck (100,200), slot 5 valid (110,210), frame_start -> kill_addr=5, hit, kill 1 cycle
//    12 cycles after frame_start, score=1, busy=0 one cycle after.
//  3 Shot (96,200) with SHOT_W=4 touching the duck's left edge -> no hit;
//    busy high for 128 cycles.
//  4 Slots 3 and 7 both overlapping -> only slot 3 killed, score +1.
//  5 Drop duck_alive while scanning slot 20 -> IDLE next edge, no hit.
//  6 score preloaded to 0xFFFF, then a hit -> score stays 0xFFFF, hit still pulses.

Source files
------------

// File: rtl/shot_hit_scanner_pkg.sv
// Shared definitions for the shot-table scanner: FSM encoding, box sizes,
// coordinate widths and the coordinate extension helpers.
package shot_hit_scanner_pkg;

    localparam int COORD_W     = 10;  // screen coordinate width
    localparam int CALC_W      = 12;  // signed width used for box arithmetic
    localparam int SLOT_COUNT  = 64;
    localparam int SLOT_ADDR_W = 6;
    localparam int DUCK_BOX_W  = 32;
    localparam int DUCK_BOX_H  = 32;
    localparam int SHOT_BOX_W  = 4;
    localparam int SHOT_BOX_H  = 8;
    localparam int SCORE_BITS  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2,
        ST_KILL  = 2'd3
    } scan_state_e;

    // x coordinates are unsigned screen positions
    function automatic logic signed [CALC_W-1:0] ext_x(input logic [COORD_W-1:0] x);
        return $signed({{(CALC_W-COORD_W){1'b0}}, x});
    endfunction

    // y coordinates are signed so objects can sit partly above the screen
    function automatic logic signed [CALC_W-1:0] ext_y(input logic [COORD_W-1:0] y);
        return $signed({{(CALC_W-COORD_W){y[COORD_W-1]}}, y});
    endfunction

endpackage

// File: rtl/shot_hit_scanner_if.sv
// Read/clear port between the scanner and the shot table.
interface shot_hit_scanner_if
    import shot_hit_scanner_pkg::*;
#(
    parameter int ADDR_W = SLOT_ADDR_W
) ();

    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_valid;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               kill;
    logic [ADDR_W-1:0]  kill_addr;

    modport master (
        output rd_addr,
        output kill,
        output kill_addr,
        input  rd_valid,
        input  rd_x,
        input  rd_y
    );

    modport slave (
        input  rd_addr,
        input  kill,
        input  kill_addr,
        output rd_valid,
        output rd_x,
        output rd_y
    );

endinterface

// File: rtl/shot_hit_scanner_box_overlap.sv
// Combinational axis-aligned box overlap test. Box A and box B are given by
// their top-left corners; sizes are parameters. Touching edges do not count.
module box_overlap
    import shot_hit_scanner_pkg::*;
#(
    parameter int A_W = SHOT_BOX_W,
    parameter int A_H = SHOT_BOX_H,
    parameter int B_W = DUCK_BOX_W,
    parameter int B_H = DUCK_BOX_H
) (
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    output logic               overlap
);

    localparam logic signed [CALC_W-1:0] A_W_S = CALC_W'(A_W);
    localparam logic signed [CALC_W-1:0] A_H_S = CALC_W'(A_H);
    localparam logic signed [CALC_W-1:0] B_W_S = CALC_W'(B_W);
    localparam logic signed [CALC_W-1:0] B_H_S = CALC_W'(B_H);

    logic signed [CALC_W-1:0] ax_s;
    logic signed [CALC_W-1:0] ay_s;
    logic signed [CALC_W-1:0] bx_s;
    logic signed [CALC_W-1:0] by_s;

    assign ax_s = ext_x(a_x);
    assign ay_s = ext_y(a_y);
    assign bx_s = ext_x(b_x);
    assign by_s = ext_y(b_y);

    // 12-bit signed range leaves headroom for coordinate plus box size
    assign overlap = ((ax_s + A_W_S) > bx_s) &&
                     (ax_s < (bx_s + B_W_S)) &&
                     ((ay_s + A_H_S) > by_s) &&
                     (ay_s < (by_s + B_H_S));

endmodule

// File: rtl/shot_hit_scanner.sv
// Once per frame, walks every shot slot through the table's 1-cycle read port
// and kills the first valid shot overlapping the live duck. Keeps a saturating
// hit score.
module shot_hit_scanner
    import shot_hit_scanner_pkg::*;
#(
    parameter int N_SLOTS = SLOT_COUNT,
    parameter int ADDR_W  = SLOT_ADDR_W,
    parameter int DUCK_W  = DUCK_BOX_W,
    parameter int DUCK_H  = DUCK_BOX_H,
    parameter int SHOT_W  = SHOT_BOX_W,
    parameter int SHOT_H  = SHOT_BOX_H,
    parameter int SCORE_W = SCORE_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [COORD_W-1:0]   duck_x,
    input  logic [COORD_W-1:0]   duck_y,
    input  logic                 duck_alive,
    shot_hit_scanner_if.master   tbl,
    output logic                 hit,
    output logic [SCORE_W-1:0]   score,
    output logic                 busy
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_SLOTS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    scan_state_e         state_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic                kill_r;
    logic [ADDR_W-1:0]   kill_addr_r;
    logic                hit_r;
    logic [SCORE_W-1:0]  score_r;
    logic                busy_r;
    logic                box_hit_s;
    logic                overlap_s;

    box_overlap #(
        .A_W (SHOT_W),
        .A_H (SHOT_H),
        .B_W (DUCK_W),
        .B_H (DUCK_H)
    ) u_box_overlap (
        .a_x     (tbl.rd_x),
        .a_y     (tbl.rd_y),
        .b_x     (duck_x),
        .b_y     (duck_y),
        .overlap (box_hit_s)
    );

    // Only meaningful in CHECK, when the table data belongs to rd_addr_r
    assign overlap_s = tbl.rd_valid & box_hit_s;

    // Scan FSM with slot address, kill/hit pulses, busy flag and score
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rd_addr_r   <= '0;
            kill_r      <= 1'b0;
            kill_addr_r <= '0;
            hit_r       <= 1'b0;
            score_r     <= '0;
            busy_r      <= 1'b0;
        end else begin
            kill_r <= 1'b0;
            hit_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (frame_start && duck_alive) begin
                        rd_addr_r <= '0;
                        busy_r    <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else begin
                        busy_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (!duck_alive) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!duck_alive) begin
                        // overlap seen in this cycle is discarded
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (overlap_s) begin
                        kill_addr_r <= rd_addr_r;
                        kill_r      <= 1'b1;
                        hit_r       <= 1'b1;
                        if (score_r != '1) begin
                            score_r <= score_r + SCORE_ONE;
                        end else begin
                            score_r <= score_r;
                        end
                        state_r     <= ST_KILL;
                    end else if (rd_addr_r == LAST_ADDR) begin
                        // scan complete, address parks on the last slot
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        rd_addr_r <= rd_addr_r + ADDR_ONE;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_KILL: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tbl.rd_addr   = rd_addr_r;
    assign tbl.kill      = kill_r;
    assign tbl.kill_addr = kill_addr_r;
    assign hit           = hit_r;
    assign score         = score_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_shot_hit_scanner.sv
// Scoreboard bench for shot_hit_scanner: stimulus pushes expected kills,
// a monitor pops and compares whenever kill/hit is presented.
module tb_shot_hit_scanner;
    import shot_hit_scanner_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_start;
    logic        frame_start2;
    logic [9:0]  duck_x;
    logic [9:0]  duck_y;
    logic        duck_alive;
    logic        hit;
    logic [15:0] score;
    logic        busy;
    logic        hit2;
    logic [2:0]  score2;
    logic        busy2;

    always #5 clk = ~clk;

    shot_hit_scanner_if tbl_if ();
    shot_hit_scanner_if sat_if ();

    shot_hit_scanner dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .duck_x      (duck_x),
        .duck_y      (duck_y),
        .duck_alive  (duck_alive),
        .tbl         (tbl_if),
        .hit         (hit),
        .score       (score),
        .busy        (busy)
    );

    // Narrow score instance so saturation is reachable in a short run
    shot_hit_scanner #(.SCORE_W(3)) dut_sat (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start2),
        .duck_x      (duck_x),
        .duck_y      (duck_y),
        .duck_alive  (duck_alive),
        .tbl         (sat_if),
        .hit         (hit2),
        .score       (score2),
        .busy        (busy2)
    );

    assign sat_if.rd_valid = 1'b1;
    assign sat_if.rd_x     = 10'd110;
    assign sat_if.rd_y     = 10'd210;

    // Shot table model: written only by the stimulus process
    logic       tbl_v [64];
    logic [9:0] tbl_x [64];
    logic [9:0] tbl_y [64];

    always @(posedge clk) begin
        tbl_if.rd_valid <= tbl_v[tbl_if.rd_addr];
        tbl_if.rd_x     <= tbl_x[tbl_if.rd_addr];
        tbl_if.rd_y     <= tbl_y[tbl_if.rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] score;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   t_start = 0;
    bit   chk_busy_next = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: compare every presented kill/hit against the scoreboard
    always @(negedge clk) begin
        if (chk_busy_next) begin
            chk("busy_after_kill", 32'(busy), 32'd0);
            chk_busy_next = 1'b0;
        end
        if (reset !== 1'b1 && (tbl_if.kill === 1'b1 || hit === 1'b1)) begin
            chk("hit_eq_kill", 32'(hit), 32'(tbl_if.kill));
            if (exp_q.size() == 0) begin
                chk("unexpected_kill", 32'(tbl_if.kill_addr), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("kill_addr", 32'(tbl_if.kill_addr), 32'(e.addr));
                chk("score", 32'(score), 32'(e.score));
                chk("kill_latency", 32'(cyc - t_start), 32'(e.lat));
                chk_busy_next = 1'b1;
            end
        end
    end

    task automatic clear_table();
        for (int i = 0; i < 64; i++) begin
            tbl_v[i] = 1'b0;
            tbl_x[i] = 10'd0;
            tbl_y[i] = 10'd0;
        end
    endtask

    task automatic set_slot(input int s, input logic [9:0] x, input logic [9:0] y);
        tbl_v[s] = 1'b1;
        tbl_x[s] = x;
        tbl_y[s] = y;
    endtask

    task automatic start_frame();
        @(negedge clk);
        frame_start = 1'b1;
        t_start = cyc + 1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_addr(input logic [5:0] a);
        int n = 0;
        while (tbl_if.rd_addr !== a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("addr_timeout", 32'(tbl_if.rd_addr), 32'(a));
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        frame_start  = 1'b0;
        frame_start2 = 1'b0;
        duck_x       = 10'd100;
        duck_y       = 10'd200;
        duck_alive   = 1'b1;
        clear_table();
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_rd_addr", 32'(tbl_if.rd_addr), 32'd0);
        chk("rst_kill", 32'(tbl_if.kill), 32'd0);
        chk("rst_kill_addr", 32'(tbl_if.kill_addr), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: reset in the middle of a scan
        start_frame();
        chk("t1_busy_on", 32'(busy), 32'd1);
        wait_addr(6'd10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_rd_addr", 32'(tbl_if.rd_addr), 32'd0);
        chk("t1_kill", 32'(tbl_if.kill), 32'd0);
        chk("t1_score", 32'(score), 32'd0);
        repeat (2) @(negedge clk);

        // 2: single hit on slot 5
        clear_table();
        set_slot(5, 10'd110, 10'd210);
        exp_q.push_back('{addr: 6'd5, score: 16'd1, lat: 12});
        start_frame();
        wait_idle();

        // 3: touching edges only, full-length scan
        clear_table();
        set_slot(0, 10'd96, 10'd200);   // touches left edge
        set_slot(1, 10'd110, 10'd192);  // touches top edge
        set_slot(2, 10'd132, 10'd210);  // touches right edge
        set_slot(3, 10'd110, 10'd232);  // touches bottom edge
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("t3_busy_cycles", 32'(n), 32'd128);
        chk("t3_rd_addr_end", 32'(tbl_if.rd_addr), 32'd63);
        repeat (2) @(negedge clk);
        chk("t3_score", 32'(score), 32'd1);

        // 4: two overlapping slots, only the first is killed
        clear_table();
        set_slot(3, 10'd110, 10'd210);
        set_slot(7, 10'd110, 10'd210);
        exp_q.push_back('{addr: 6'd3, score: 16'd2, lat: 8});
        start_frame();
        wait_idle();

        // 5: duck dies during the CHECK cycle of an overlapping slot
        clear_table();
        set_slot(20, 10'd110, 10'd210);
        set_slot(25, 10'd110, 10'd210);
        start_frame();
        wait_addr(6'd20);
        @(negedge clk);
        duck_alive = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        duck_alive = 1'b1;
        repeat (70) @(negedge clk);
        chk("t5_score", 32'(score), 32'd2);
        chk("t5_busy_idle", 32'(busy), 32'd0);

        // 7: signed y, duck partly above the screen
        clear_table();
        duck_y = 10'h3F6;                  // -10
        set_slot(2, 10'd105, 10'h3E0);     // -32: bottom at -24, no overlap
        set_slot(9, 10'd105, 10'd5);
        exp_q.push_back('{addr: 6'd9, score: 16'd3, lat: 20});
        start_frame();
        wait_idle();
        duck_y = 10'd200;

        // 6: score saturation on the 3-bit instance
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            frame_start2 = 1'b1;
            @(negedge clk);
            frame_start2 = 1'b0;
            n = 0;
            while (sat_if.kill !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_kill", 32'(sat_if.kill), 32'd1);
            chk("t6_hit", 32'(hit2), 32'd1);
            chk("t6_score", 32'(score2), (i < 7) ? 32'(i + 1) : 32'd7);
            @(negedge clk);
        end

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
